serial_adder_ctrl: RTL and testbench

Bit-serial adder controller that sequences one instance of the team's `fulladder` cell to add two WIDTH-bit operands, LSB first, one bit per clock. Requests are accepted through a valid/ready handshake and results are returned through a second valid/ready handshake. The block lets the FPGAController datapath perform multi-bit additions with a single 1-bit adder, trading latency for area.

---
 rtl/serial_adder_pkg.sv | 13 +
 rtl/serial_adder_ctrl_fulladder.sv | 20 ++
 rtl/serial_adder_ctrl.sv | 133 +++++++++++++
 tb/tb_serial_adder_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
// Shared types and constants for the bit-serial adder controller.
//   sa_state_t   : controller state encoding (IDLE, SHIFT, DONE)
//   SA_WIDTH_DEF : default operand/result width
// -----------------------------------------------------------------------------
package serial_adder_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} sa_state_t;

    localparam int unsigned SA_WIDTH_DEF = 8;

endpackage

// File: rtl/serial_adder_ctrl_fulladder.sv
// -----------------------------------------------------------------------------
// fulladder
// One-bit full adder cell shared by the serial adder datapath.
// Ports:
//   A, B, Cin : input bits
//   S         : sum bit
//   Cout      : carry out
// -----------------------------------------------------------------------------
module fulladder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic S,
    output logic Cout
);

    assign S    = A ^ B ^ Cin;
    assign Cout = (A & B) | (A & Cin) | (B & Cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl
// Adds two WIDTH-bit operands LSB first, one bit per clock, through a single
// fulladder instance. Requests arrive on a valid/ready handshake and results
// leave on a second valid/ready handshake. Latency is WIDTH cycles.
//
// Build option: define SERIAL_ADDER_OVF_EN to add the signed-overflow output
// `ovf`; left undefined, the port and its logic are absent.
//
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   req_valid/req_ready : request handshake (ready only in IDLE)
//   a, b, cin           : operands, sampled on request acceptance
//   res_valid/res_ready : result handshake (valid only in DONE)
//   sum, cout           : registered result and final carry
//   ovf                 : signed overflow (SERIAL_ADDER_OVF_EN only)
// -----------------------------------------------------------------------------
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = SA_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int unsigned    BCW  = $clog2(WIDTH + 1);
    localparam logic [BCW-1:0] LAST = BCW'(WIDTH - 1);

    sa_state_t        r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic [BCW-1:0]   r_bit_cnt;
`ifdef SERIAL_ADDER_OVF_EN
    logic             r_ovf;
`endif

    logic             w_fa_s;
    logic             w_fa_cout;
    logic [WIDTH-1:0] w_sum_next;

    fulladder u_fa (
        .A    (r_a_sh[0]),
        .B    (r_b_sh[0]),
        .Cin  (r_carry),
        .S    (w_fa_s),
        .Cout (w_fa_cout)
    );

    // New sum bit enters at the MSB; written this way so WIDTH=1 needs no
    // empty slice.
    always_comb begin
        w_sum_next            = r_sum >> 1;
        w_sum_next[WIDTH-1]   = w_fa_s;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_a_sh    <= '0;
            r_b_sh    <= '0;
            r_sum     <= '0;
            r_carry   <= 1'b0;
            r_cout    <= 1'b0;
            r_bit_cnt <= '0;
`ifdef SERIAL_ADDER_OVF_EN
            r_ovf     <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_a_sh    <= a;
                        r_b_sh    <= b;
                        r_carry   <= cin;
                        r_sum     <= '0;
                        r_cout    <= 1'b0;
                        r_bit_cnt <= '0;
`ifdef SERIAL_ADDER_OVF_EN
                        r_ovf     <= 1'b0;
`endif
                        r_state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_sum     <= w_sum_next;
                    r_a_sh    <= r_a_sh >> 1;
                    r_b_sh    <= r_b_sh >> 1;
                    r_carry   <= w_fa_cout;
                    r_bit_cnt <= r_bit_cnt + BCW'(1);
                    if (r_bit_cnt == LAST) begin
                        r_cout  <= w_fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
                        // r_carry here is the carry into the MSB
                        r_ovf   <= r_carry ^ w_fa_cout;
`endif
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready = (r_state == IDLE);
    assign res_valid = (r_state == DONE);
    assign sum       = r_sum;
    assign cout      = r_cout;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf       = r_ovf;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_adder_ctrl
// Self-checking bench for serial_adder_ctrl: an 8-bit instance driven with
// directed and random requests (with random result backpressure) and a 1-bit
// instance swept through the full-adder truth table. Expected results come
// from plain integer addition of the operands.
// -----------------------------------------------------------------------------
module tb_serial_adder_ctrl;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;

    logic         req_valid, req_ready, res_valid, res_ready, cin, cout;
    logic [W-1:0] a, b, sum;

    logic         u1_req_valid, u1_req_ready, u1_res_valid, u1_res_ready;
    logic         u1_a, u1_b, u1_cin, u1_sum, u1_cout;

`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf, u1_ovf;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .sum       (sum),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf       (ovf),
`endif
        .cout      (cout)
    );

    serial_adder_ctrl #(.WIDTH(1)) dut_w1 (
        .clk       (clk),
        .rst       (rst),
        .req_valid (u1_req_valid),
        .req_ready (u1_req_ready),
        .a         (u1_a),
        .b         (u1_b),
        .cin       (u1_cin),
        .res_valid (u1_res_valid),
        .res_ready (u1_res_ready),
        .sum       (u1_sum),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf       (u1_ovf),
`endif
        .cout      (u1_cout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full request/result exchange on the 8-bit instance. hold = number
    // of cycles res_ready stays low after res_valid rises (0 = ready early).
    task automatic do_txn(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input logic tcin, input int hold);
        logic [W:0]   exp;
        logic [W-1:0] held_sum;
        logic         held_cout;
        logic         exp_ovf;
        int           n;
        bit           rdy_bad, stable_bad;

        exp     = {1'b0, ta} + {1'b0, tb_} + {{W{1'b0}}, tcin};
        exp_ovf = (ta[W-1] == tb_[W-1]) && (exp[W-1] != ta[W-1]);

        check("rdy_idle", 32'(req_ready), 32'd1);
        a = ta; b = tb_; cin = tcin;
        req_valid = 1'b1;
        res_ready = (hold == 0);
        tick();                                // acceptance edge E0
        req_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);

        n = 0;
        rdy_bad = 1'b0;
        while (!res_valid && n < int'(W) + 4) begin
            if (req_ready) rdy_bad = 1'b1;
            tick();
            n++;
        end
        check("latency", 32'(n), 32'(W));
        check("sum", 32'(sum), 32'(exp[W-1:0]));
        check("cout", 32'(cout), 32'(exp[W]));
`ifdef SERIAL_ADDER_OVF_EN
        check("ovf", 32'(ovf), 32'(exp_ovf));
`else
        if (exp_ovf) begin end
`endif

        if (hold > 0) begin
            held_sum   = sum;
            held_cout  = cout;
            stable_bad = 1'b0;
            for (int i = 0; i < hold; i++) begin
                req_valid = 1'b1;              // must be ignored in DONE
                a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
                tick();
                if (sum !== held_sum || cout !== held_cout || res_valid !== 1'b1)
                    stable_bad = 1'b1;
                if (req_ready) rdy_bad = 1'b1;
            end
            check("bp_stable", 32'(stable_bad), 32'd0);
            req_valid = 1'b0;
            res_ready = 1'b1;
        end
        check("rdy_busy", 32'(rdy_bad), 32'd0);

        tick();                                // result transfer edge
        check("xfer_valid", 32'(res_valid), 32'd0);
        check("xfer_ready", 32'(req_ready), 32'd1);
        check("sum_hold", 32'(sum), 32'(exp[W-1:0]));
        res_ready = 1'b0;

        if (hold > 0) begin
            tick();
            check("no_queue", 32'(req_ready), 32'd1);
        end
    endtask

    initial begin
        logic [2:0] v;
        int         s1;

        rst = 1'b1;
        req_valid = 1'b0; res_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
        u1_req_valid = 1'b0; u1_res_ready = 1'b0;
        u1_a = 1'b0; u1_b = 1'b0; u1_cin = 1'b0;

        #12;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        check("rst_ovf", 32'(ovf), 32'd0);
`endif
        tick();
        rst = 1'b0;
        tick();

        // directed cases
        do_txn(8'h5A, 8'h3C, 1'b0, 0);
        do_txn(8'hFF, 8'h01, 1'b0, 0);
        do_txn(8'h00, 8'h00, 1'b1, 0);
        do_txn(8'h5A, 8'h3C, 1'b1, 5);

        // reset in the middle of SHIFT
        a = 8'h5A; b = 8'h3C; cin = 1'b0; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick(); tick(); tick();
        #2 rst = 1'b1;
        #1;
        check("mid_rst_ready", 32'(req_ready), 32'd1);
        check("mid_rst_valid", 32'(res_valid), 32'd0);
        check("mid_rst_sum", 32'(sum), 32'd0);
        check("mid_rst_cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        check("mid_rst_ovf", 32'(ovf), 32'd0);
`endif
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_valid", 32'(res_valid), 32'd0);
        do_txn(8'h01, 8'h02, 1'b0, 0);

        // random traffic with random backpressure
        for (int t = 0; t < 24; t++) begin
            do_txn(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        end

        // WIDTH=1 truth-table sweep
        for (int k = 0; k < 8; k++) begin
            v = 3'(k);
            s1 = int'(v[2]) + int'(v[1]) + int'(v[0]);
            u1_a = v[2]; u1_b = v[1]; u1_cin = v[0];
            u1_req_valid = 1'b1;
            u1_res_ready = 1'b1;
            tick();
            u1_req_valid = 1'b0;
            check("w1_busy", 32'(u1_req_ready), 32'd0);
            tick();
            check("w1_valid", 32'(u1_res_valid), 32'd1);
            check("w1_result", 32'({u1_cout, u1_sum}), 32'(s1));
`ifdef SERIAL_ADDER_OVF_EN
            check("w1_ovf", 32'(u1_ovf), 32'((v[2] == v[1]) && (1'(s1) != v[2])));
`endif
            tick();
            check("w1_xfer", 32'(u1_res_valid), 32'd0);
            u1_res_ready = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard stop in case a handshake never completes.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
